branch_resolve_unit: RTL

//  Multi-cycle branch resolver placed directly around the 16-bit magnitude comparator (comp_16_bit).

---
 rtl/cpu_branch_pkg.sv | 28 ++
 rtl/br_cond_eval.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_branch_pkg.sv
// Package: cpu_branch_pkg
// Shared types for the branch resolve unit.
//   cond_e      - 3-bit branch condition encodings as presented on br_cond.
//   brs_state_e - resolver sequencing states.
//   PC_STEP     - fall-through increment for a word-addressed PC.
package cpu_branch_pkg;

   typedef enum logic [2:0] {
      COND_EQ     = 3'd0,
      COND_NE     = 3'd1,
      COND_LT     = 3'd2,
      COND_GT     = 3'd3,
      COND_LE     = 3'd4,
      COND_GE     = 3'd5,
      COND_ALWAYS = 3'd6,
      COND_NEVER  = 3'd7
   } cond_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RESOLVE = 2'd2,
      RESP    = 2'd3
   } brs_state_e;

   localparam int PC_STEP = 1;

endpackage

// File: rtl/br_cond_eval.sv
// Module: br_cond_eval
// Purely combinational branch-condition evaluator.
//   cond  in  condition code (cond_e)
//   lt    in  captured inp1 <  inp2
//   gt    in  captured inp1 >  inp2
//   eq    in  captured inp1 == inp2
//   err   in  captured flags were not one-hot
//   taken out branch is taken
module br_cond_eval
   import cpu_branch_pkg::*;
(
   input  cond_e cond,
   input  logic  lt,
   input  logic  gt,
   input  logic  eq,
   input  logic  err,
   output logic  taken
);

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         COND_EQ:     taken = eq;
         COND_NE:     taken = !eq;
         COND_LT:     taken = lt;
         COND_GT:     taken = gt;
         COND_LE:     taken = lt | eq;
         COND_GE:     taken = gt | eq;
         COND_ALWAYS: taken = 1'b1;
         COND_NEVER:  taken = 1'b0;
         default:     taken = 1'b0;
      endcase
      // Untrustworthy flags can never produce a conditional redirect;
      // an unconditional branch does not depend on them at all.
      if (err && (cond != COND_ALWAYS)) begin
         taken = 1'b0;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Module: branch_resolve_unit
// Multi-cycle branch resolver wrapped around an external 16-bit magnitude
// comparator. Sequence: IDLE (accept) -> CAPTURE (sample flags) ->
// RESOLVE (evaluate, compute next PC) -> RESP (hold result until ack).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   br_valid/br_ready              request handshake (ready only in IDLE)
//   br_cond, br_opa, br_opb        condition code and compare operands
//   br_pc, br_offset               branch PC and PC-relative offset
//   cmp_inp1/cmp_inp2              registered operands to the comparator
//   cmp_less/greater/equal         comparator result flags
//   res_valid/res_ack              resolution handshake to fetch
//   res_taken, res_pc              resolved direction and next PC
//   flush                          one-cycle pulse when a taken result appears
//   flag_lt/gt/eq                  last captured comparator flags
//   cmp_err                        sticky: captured flags were not one-hot
module branch_resolve_unit
   import cpu_branch_pkg::*;
#(
   parameter int N    = 16,
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      br_cond,
   input  logic [N-1:0]    br_opa,
   input  logic [N-1:0]    br_opb,
   input  logic [PC_W-1:0] br_pc,
   input  logic [PC_W-1:0] br_offset,
   output logic [N-1:0]    cmp_inp1,
   output logic [N-1:0]    cmp_inp2,
   input  logic            cmp_less,
   input  logic            cmp_greater,
   input  logic            cmp_equal,
   output logic            res_valid,
   input  logic            res_ack,
   output logic            res_taken,
   output logic [PC_W-1:0] res_pc,
   output logic            flush,
   output logic            flag_lt,
   output logic            flag_gt,
   output logic            flag_eq,
   output logic            cmp_err
);

   brs_state_e      state_reg;
   logic [N-1:0]    opa_reg;
   logic [N-1:0]    opb_reg;
   cond_e           cond_reg;
   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] offset_reg;
   logic            flag_lt_reg;
   logic            flag_gt_reg;
   logic            flag_eq_reg;
   logic            bad_flags_reg;
   logic            cmp_err_reg;
   logic            br_ready_reg;
   logic            res_valid_reg;
   logic            res_taken_reg;
   logic [PC_W-1:0] res_pc_reg;
   logic            flush_reg;

   logic            flags_one_hot;
   logic            eval_taken;
   logic [PC_W-1:0] target_pc;
   logic [PC_W-1:0] fall_pc;

   // Exactly one of three: odd parity rules out 0 and 2 set, the AND
   // term rules out all three set.
   assign flags_one_hot = (cmp_less ^ cmp_greater ^ cmp_equal) &
                          !(cmp_less & cmp_greater & cmp_equal);

   // Modulo 2^PC_W arithmetic; carries out of the top bit are discarded.
   assign target_pc = pc_reg + offset_reg;
   assign fall_pc   = pc_reg + PC_W'(PC_STEP);

   br_cond_eval u_cond_eval (
      .cond  (cond_reg),
      .lt    (flag_lt_reg),
      .gt    (flag_gt_reg),
      .eq    (flag_eq_reg),
      .err   (bad_flags_reg),
      .taken (eval_taken)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         opa_reg       <= '0;
         opb_reg       <= '0;
         cond_reg      <= COND_EQ;
         pc_reg        <= '0;
         offset_reg    <= '0;
         flag_lt_reg   <= 1'b0;
         flag_gt_reg   <= 1'b0;
         flag_eq_reg   <= 1'b0;
         bad_flags_reg <= 1'b0;
         cmp_err_reg   <= 1'b0;
         br_ready_reg  <= 1'b1;
         res_valid_reg <= 1'b0;
         res_taken_reg <= 1'b0;
         res_pc_reg    <= '0;
         flush_reg     <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (br_valid && br_ready_reg) begin
                  opa_reg      <= br_opa;
                  opb_reg      <= br_opb;
                  cond_reg     <= cond_e'(br_cond);
                  pc_reg       <= br_pc;
                  offset_reg   <= br_offset;
                  br_ready_reg <= 1'b0;
                  state_reg    <= CAPTURE;
               end
            end
            CAPTURE: begin
               // Comparator has seen the operand registers for a full cycle.
               flag_lt_reg   <= cmp_less;
               flag_gt_reg   <= cmp_greater;
               flag_eq_reg   <= cmp_equal;
               bad_flags_reg <= !flags_one_hot;
               if (!flags_one_hot && (cond_reg != COND_ALWAYS)) begin
                  cmp_err_reg <= 1'b1;
               end
               state_reg <= RESOLVE;
            end
            RESOLVE: begin
               res_taken_reg <= eval_taken;
               res_pc_reg    <= eval_taken ? target_pc : fall_pc;
               res_valid_reg <= 1'b1;
               flush_reg     <= eval_taken;
               state_reg     <= RESP;
            end
            RESP: begin
               flush_reg <= 1'b0;
               if (res_ack) begin
                  res_valid_reg <= 1'b0;
                  br_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign br_ready  = br_ready_reg;
   assign cmp_inp1  = opa_reg;
   assign cmp_inp2  = opb_reg;
   assign res_valid = res_valid_reg;
   assign res_taken = res_taken_reg;
   assign res_pc    = res_pc_reg;
   assign flush     = flush_reg;
   assign flag_lt   = flag_lt_reg;
   assign flag_gt   = flag_gt_reg;
   assign flag_eq   = flag_eq_reg;
   assign cmp_err   = cmp_err_reg;

endmodule
